nibble_serial_adder: RTL and testbench

//  Multi-nibble sequential adder built on the existing four_bitadder stage.

---
 rtl/nibble_serial_adder.sv | 182 ++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Purpose : serial adder that adds two 4*NIBBLES-bit operands one nibble per
//           cycle through a single four_bitadder stage, LSB nibble first.
// Latency : out_valid rises NIBBLES clock edges after the accepting edge.
// Backpressure: one operation in flight; in_ready drops from accept until the
//           result is taken. While out_ready is low the result is held in DONE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands in_a / in_b / in_cin are valid
//   in_ready   block is idle and can accept operands
//   in_a, in_b WIDTH-bit operands (WIDTH = 4*NIBBLES)
//   in_cin     carry into nibble 0
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_sum    low WIDTH bits of a+b+cin
//   out_cout   carry out of the top nibble
//   out_ovf    two's-complement overflow (bit WIDTH-1 is the sign)

// Purpose : 4-bit ripple-carry adder stage, one nibble of the serial adder.
// Latency : purely combinational.
// Backpressure: none; no handshake.
//
// Ports: a, b (4-bit addends), cin (carry in), s (4-bit sum), cout (carry out).
module four_bitadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  // Carries are kept as separate scalars so the ripple chain is not a
  // self-referencing vector.
  logic c1;
  logic c2;
  logic c3;

  always_comb begin
    s[0] = a[0] ^ b[0] ^ cin;
    c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    s[1] = a[1] ^ b[1] ^ c1;
    c2   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    s[2] = a[2] ^ b[2] ^ c2;
    c3   = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    s[3] = a[3] ^ b[3] ^ c3;
    cout = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int WIDTH = 4 * NIBBLES;
  // A single-nibble build still carries a 1-bit index so the logic stays uniform.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  // Nibble currently presented to the adder stage.
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       add_s;
  logic             add_cout;

  // Operand sign bits; only meaningful once the operands are latched.
  logic             a_msb;
  logic             b_msb;

  assign a_msb = a_reg[WIDTH-1];
  assign b_msb = b_reg[WIDTH-1];

  // Explicit compare-and-select instead of a variable part-select keeps the
  // mux in range when NIBBLES is not a power of two.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_a = a_reg[4*i +: 4];
        nib_b = b_reg[4*i +: 4];
      end
    end
  end

  four_bitadder u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the accept.
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
              sum_reg[4*i +: 4] <= add_s;
            end
          end
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_reg <= add_cout;
            // Overflow: like-signed operands producing a result of the other sign.
            ovf_reg  <= (a_msb == b_msb) && (add_s[3] != a_msb);
            state    <= DONE;
          end
        end

        DONE: begin
          // Result registers are untouched here, so they hold until taken.
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;

  // Default build: NIBBLES = 4 (16-bit operands)
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  // Single-nibble build: NIBBLES = 1
  logic        n1_in_valid;
  logic        n1_in_ready;
  logic [3:0]  n1_in_a;
  logic [3:0]  n1_in_b;
  logic        n1_in_cin;
  logic        n1_out_valid;
  logic        n1_out_ready;
  logic [3:0]  n1_out_sum;
  logic        n1_out_cout;
  logic        n1_out_ovf;

  int checks;
  int failures;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (n1_in_valid),
    .in_ready  (n1_in_ready),
    .in_a      (n1_in_a),
    .in_b      (n1_in_b),
    .in_cin    (n1_in_cin),
    .out_valid (n1_out_valid),
    .out_ready (n1_out_ready),
    .out_sum   (n1_out_sum),
    .out_cout  (n1_out_cout),
    .out_ovf   (n1_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one operation on the 16-bit DUT and wait for its result. Returns the
  // number of edges from accept to out_valid (-1 on timeout). The handshake is
  // completed only if out_ready is high; otherwise the DUT is left in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble the inputs: latched operands must not follow them.
    in_a   = 16'($urandom);
    in_b   = 16'($urandom);
    in_cin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    s  = out_sum;
    co = out_cout;
    ov = out_ovf;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t        vecs[10];
  logic [15:0] s;
  logic        co;
  logic        ov;
  int          lat;
  logic [16:0] ref_full;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rc;
  logic        saw_valid;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_cin      = 1'b0;
    out_ready   = 1'b1;
    n1_in_valid = 1'b0;
    n1_in_a     = '0;
    n1_in_b     = '0;
    n1_in_cin   = 1'b0;
    n1_out_ready = 1'b1;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[9] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_cout",  32'(out_cout),  32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_n1_ready",  32'(n1_in_ready), 32'd1);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat);
      check($sformatf("vec%0d_sum", i),  32'(s),  32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i),  32'(ov), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_idle_after", i), 32'(in_ready), 32'd1);
    end

    // Random vectors against a full-width reference sum
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      run_op(ra, rb, rc, s, co, ov, lat);
      check($sformatf("rnd%0d_sum", i),  32'(s),  32'(ref_full[15:0]));
      check($sformatf("rnd%0d_cout", i), 32'(co), 32'(ref_full[16]));
      check($sformatf("rnd%0d_ovf", i),  32'(ov),
            32'((ra[15] == rb[15]) && (ref_full[15] != ra[15])));
    end

    // Backpressure: result held in DONE, new requests ignored
    out_ready = 1'b0;
    run_op(16'h7FFF, 16'h0001, 1'b0, s, co, ov, lat);
    check("bp_sum",     32'(s),   32'h8000);
    check("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'($urandom_range(0, 1)) | (k == 0);
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", k),  32'(in_ready),  32'd0);
      check($sformatf("bp%0d_sum", k),       32'(out_sum),   32'h8000);
      check($sformatf("bp%0d_cout", k),      32'(out_cout),  32'd0);
      check($sformatf("bp%0d_ovf", k),       32'(out_ovf),   32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_no_queued_op", 32'(in_ready), 32'd1);

    // Reset in the middle of RUN
    @(negedge clk);
    in_a     = 16'hFFFF;
    in_b     = 16'h0001;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_accepted", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum",   32'(out_sum),   32'd0);
    check("mid_rst_out_cout",  32'(out_cout),  32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_valid", 32'(saw_valid), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, s, co, ov, lat);
    check("post_rst_sum",     32'(s),   32'h0100);
    check("post_rst_cout",    32'(co),  32'd0);
    check("post_rst_latency", 32'(lat), 32'd4);

    // NIBBLES=1: F + 1 + 1
    @(negedge clk);
    n1_in_a     = 4'hF;
    n1_in_b     = 4'h1;
    n1_in_cin   = 1'b1;
    n1_in_valid = 1'b1;
    @(posedge clk);
    #1;
    n1_in_valid = 1'b0;
    n1_in_a     = 4'h0;
    n1_in_b     = 4'h0;
    n1_in_cin   = 1'b0;
    check("n1_busy_after_accept", 32'(n1_in_ready),  32'd0);
    check("n1_not_valid_yet",     32'(n1_out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("n1_valid_1_edge", 32'(n1_out_valid), 32'd1);
    check("n1_sum",          32'(n1_out_sum),   32'h1);
    check("n1_cout",         32'(n1_out_cout),  32'd1);
    check("n1_ovf",          32'(n1_out_ovf),   32'd0);
    @(posedge clk);
    #1;
    check("n1_idle_after", 32'(n1_in_ready),  32'd1);
    check("n1_valid_drop", 32'(n1_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
